// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: FSM states, ALU result class codes and function constants for alu_req_sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;
  localparam logic [3:0] FUNC_DIV = 4'b0011;
  function automatic logic [3:0] class_flag(input logic [1:0] c);
    return 4'b1000 >> c;
  endfunction
endpackage

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: two-way round-robin grant, history updated only on an accepted request
module alu_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant
);
  logic last_grant;
  assign grant = valid0 && valid1 ? !last_grant : valid1;
  always_ff @(posedge clk)
    if (rst) last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
endmodule

// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: two-client round-robin front end for alu_top; ALU_DIV_ZERO_CHECK_EN short-circuits divide by zero
module alu_req_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ARITH_WIDTH = 2*WIDTH,
  parameter int CMP_WIDTH = 3,
  parameter int SHIFT_WIDTH = WIDTH+1,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [3:0]             req0_func,
  input  logic [WIDTH-1:0]       req0_a,
  input  logic [WIDTH-1:0]       req0_b,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [3:0]             req1_func,
  input  logic [WIDTH-1:0]       req1_a,
  input  logic [WIDTH-1:0]       req1_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [ARITH_WIDTH-1:0] rsp_data,
  output logic                   rsp_carry,
  output logic                   rsp_err,
  output logic [3:0]             alu_func,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  input  logic [ARITH_WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0]       logic_out,
  input  logic [CMP_WIDTH-1:0]   cmp_out,
  input  logic [SHIFT_WIDTH-1:0] shift_out,
  input  logic                   arith_flag,
  input  logic                   logic_flag,
  input  logic                   cmp_flag,
  input  logic                   shift_flag,
  input  logic                   carry_out
);
  localparam int CW = $clog2(ALU_LAT+1);
  state_t state;
  logic [CW-1:0] cnt;
  logic grant, hs, div_zero;
  logic [3:0] sel_func;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0] cls;
  logic [ARITH_WIDTH-1:0] fold;
  assign req0_ready = state == IDLE && !grant;
  assign req1_ready = state == IDLE && grant;
  assign hs = grant ? req1_valid && req1_ready : req0_valid && req0_ready;
  assign sel_func = grant ? req1_func : req0_func;
  assign sel_a = grant ? req1_a : req0_a;
  assign sel_b = grant ? req1_b : req0_b;
`ifdef ALU_DIV_ZERO_CHECK_EN
  assign div_zero = sel_func == FUNC_DIV && sel_b == '0;
`else
  assign div_zero = 1'b0;
`endif
  assign cls = alu_func[3:2];
  assign fold = cls == ARITH ? arith_out :
                cls == LOGIC ? ARITH_WIDTH'(logic_out) :
                cls == CMP   ? ARITH_WIDTH'(cmp_out) : ARITH_WIDTH'(shift_out);
  alu_rr_arbiter u_arb (
    .clk(clk), .rst(rst), .valid0(req0_valid), .valid1(req1_valid), .accept(hs), .grant(grant)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      alu_func <= '0;
      alu_a <= '0;
      alu_b <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          rsp_id <= grant;
          if (div_zero) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_data <= '0;
            rsp_carry <= 1'b0;
          end else begin
            state <= ISSUE;
            alu_func <= sel_func;
            alu_a <= sel_a;
            alu_b <= sel_b;
          end
        end
        ISSUE: begin
          cnt <= CW'(ALU_LAT-1);
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_data <= fold;
          rsp_carry <= carry_out;
          rsp_err <= {arith_flag, logic_flag, cmp_flag, shift_flag} != class_flag(cls);
        end else cnt <= cnt - 1'b1;
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_sequencer.sv
// tb_alu_req_sequencer: directed table-driven bench with a one-cycle behavioural ALU
module tb_alu_req_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [3:0] req0_func = '0, req1_func = '0, alu_func;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0, alu_a, alu_b;
  logic rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_carry, rsp_err;
  logic [31:0] rsp_data, arith_out;
  logic [15:0] logic_out;
  logic [2:0] cmp_out;
  logic [16:0] shift_out;
  logic arith_flag, logic_flag, cmp_flag, shift_flag, carry_out;
  logic [3:0] mask = '0;
  int checks = 0, errors = 0, cyc = 0, acc = 0;

  alu_req_sequencer dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [31:0] ea, eb;
  logic [16:0] sum17;
  assign ea = $signed(alu_a);
  assign eb = $signed(alu_b);
  assign sum17 = {1'b0, alu_a} + {1'b0, alu_b};
  always @(posedge clk) begin
    arith_out <= alu_func[1:0] == 2'd0 ? ea + eb :
                 alu_func[1:0] == 2'd1 ? ea - eb :
                 alu_func[1:0] == 2'd2 ? ea * eb : (eb == 0 ? 32'd0 : ea / eb);
    logic_out <= alu_func[1:0] == 2'd0 ? alu_a & alu_b :
                 alu_func[1:0] == 2'd1 ? alu_a | alu_b :
                 alu_func[1:0] == 2'd2 ? alu_a ^ alu_b : ~alu_a;
    cmp_out <= {ea < eb, ea > eb, ea == eb};
    shift_out <= {alu_a, 1'b0};
    {arith_flag, logic_flag, cmp_flag, shift_flag} <= (4'b1000 >> alu_func[3:2]) ^ mask;
    carry_out <= alu_func == 4'b0000 ? sum17[16] : 1'b0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input bit id, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_func = f; req1_a = a; req1_b = b; end
    else begin req0_valid = 1'b1; req0_func = f; req0_a = a; req0_b = b; end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 30) begin @(negedge clk); #1; n++; end
    if (n >= 30) begin checks++; errors++; $display("FAIL accept_timeout: id %0d never ready", id); end
    acc = cyc;
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic e, output logic c, output logic id, output int lat);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    if (!rsp_valid) begin checks++; errors++; $display("FAIL rsp_timeout: rsp_valid 0 expected 1"); end
    d = rsp_data; e = rsp_err; c = rsp_carry; id = rsp_id; lat = cyc - acc;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit id; logic [3:0] func; logic [15:0] a, b; logic [3:0] mask;
    logic [31:0] data; logic err, carry;
  } vec_t;
  vec_t v[12];

  initial begin
    logic [31:0] d;
    logic e, c, id;
    int lat, n, k;
    v[0]  = '{0, 4'b0000, -16'sd100, -16'sd30, 4'b0000, 32'hFFFFFF7E, 0, 1};
    v[1]  = '{1, 4'b0100, -16'sd100, -16'sd30, 4'b0000, 32'h0000FF80, 0, 0};
    v[2]  = '{1, 4'b1010, 16'd100, 16'd30, 4'b0000, 32'd2, 0, 0};
    v[3]  = '{1, 4'b1101, 16'd100, 16'd0, 4'b0000, 32'd200, 0, 0};
    v[4]  = '{0, 4'b0001, 16'd5, 16'd7, 4'b0000, 32'hFFFFFFFE, 0, 0};
    v[5]  = '{0, 4'b0110, 16'h00F0, 16'h0F0F, 4'b0000, 32'h00000FFF, 0, 0};
    v[6]  = '{1, 4'b1000, 16'd30, 16'd100, 4'b0000, 32'd4, 0, 0};
    v[7]  = '{0, 4'b1000, 16'd7, 16'd7, 4'b0000, 32'd1, 0, 0};
    v[8]  = '{0, 4'b0010, -16'sd3, 16'd4, 4'b0000, 32'hFFFFFFF4, 0, 0};
    v[9]  = '{0, 4'b0000, 16'd1, 16'd1, 4'b0001, 32'd2, 1, 0};
    v[10] = '{1, 4'b0101, 16'h00F0, 16'h0F0F, 4'b0100, 32'h00000FFF, 1, 0};
    v[11] = '{0, 4'b0011, 16'd100, 16'd7, 4'b0000, 32'd14, 0, 0};
    do_reset();
    @(negedge clk);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_carry, rsp_id}, 4'b0000);
    chk("reset_data", rsp_data, 32'd0);
    chk("reset_alu", {alu_func, alu_a, alu_b}, 36'd0);
    chk("reset_ready", {req0_ready, req1_ready}, 2'b10);
    for (int i = 0; i < 12; i++) begin
      mask = v[i].mask;
      send(v[i].id, v[i].func, v[i].a, v[i].b);
      get_rsp(d, e, c, id, lat);
      chk($sformatf("vec%0d_data", i), d, v[i].data);
      chk($sformatf("vec%0d_err", i), e, v[i].err);
      chk($sformatf("vec%0d_carry", i), c, v[i].carry);
      chk($sformatf("vec%0d_id", i), id, v[i].id);
      chk($sformatf("vec%0d_lat", i), lat, 3);
    end
    mask = '0;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_func = 4'b0000; req0_a = 16'd1; req0_b = 16'd1;
    req1_valid = 1'b1; req1_func = 4'b0000; req1_a = 16'd1; req1_b = 16'd1;
    for (k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
      chk($sformatf("rr%0d_id", k), {rsp_valid, rsp_id}, {1'b1, k[0]});
      chk($sformatf("rr%0d_data", k), rsp_data, 32'd2);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0;
    send(0, 4'b0000, 16'd2, 16'd3);
    req1_valid = 1'b1; req1_func = 4'b0000; req1_a = 16'd4; req1_b = 16'd4;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready},
          {1'b1, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {rsp_valid, req1_ready}, 2'b01);
    acc = cyc;
    @(posedge clk);
    #1 req1_valid = 1'b0;
    get_rsp(d, e, c, id, lat);
    chk("bp_next", {id, d, e}, {1'b1, 32'd8, 1'b0});
    chk("bp_next_lat", lat, 3);
    send(0, 4'b0000, 16'd9, 16'd9);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("kill_state", {rsp_valid, alu_func, alu_a, req0_ready}, {1'b0, 4'd0, 16'd0, 1'b1});
    n = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); n += int'(rsp_valid); end
    chk("kill_no_rsp", n, 0);
    send(0, 4'b0001, 16'd10, 16'd3);
    get_rsp(d, e, c, id, lat);
    chk("after_kill", {id, d, e, lat[3:0]}, {1'b0, 32'd7, 1'b0, 4'd3});
    send(0, 4'b0000, 16'd1, 16'd7);
    get_rsp(d, e, c, id, lat);
    chk("pre_div", d, 32'd8);
    send(0, 4'b0011, 16'd100, 16'd0);
    get_rsp(d, e, c, id, lat);
`ifdef ALU_DIV_ZERO_CHECK_EN
    chk("divz_lat", lat, 1);
    chk("divz_rsp", {e, c, d}, {1'b1, 1'b0, 32'd0});
    chk("divz_alu_b", alu_b, 16'd7);
`else
    chk("divz_lat", lat, 3);
    chk("divz_rsp", {e, c, d}, {1'b0, 1'b0, 32'd0});
    chk("divz_alu_b", alu_b, 16'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
